// File: rtl/calc_pkg.sv
// calc_pkg: shared types and default sizing for calc_16 and its downstream
// byte streamer (output_16).
//   op_t        operation code sampled with operand B
//   state_t     calc_16 control states
//   CALC_DATA_W / CALC_DONE_CYCLES  default operand width and result window
package calc_pkg;

    localparam int unsigned CALC_DATA_W      = 8;
    // Downstream streams one byte per cycle, so the window is 2*DATA_W/8 cycles.
    localparam int unsigned CALC_DONE_CYCLES = (2 * CALC_DATA_W) / 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_CAT = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : calc_pkg

// File: rtl/calc_16_if.sv
// calc_16_if: operand/result bus between an operand source and calc_16.
//   in_data/in_valid/op  operand byte, its valid and operation (master -> slave)
//   ans/done_calc        result and result-valid window (slave -> master)
//   err                  dropped-byte pulse, present only with CALC_ERR_EN
interface calc_16_if #(
    parameter int unsigned DATA_W = calc_pkg::CALC_DATA_W
);

    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic [1:0]          op;
    logic [2*DATA_W-1:0] ans;
    logic                done_calc;

`ifdef CALC_ERR_EN
    logic                err;

    modport master (output in_data, in_valid, op, input ans, done_calc, err);
    modport slave  (input in_data, in_valid, op, output ans, done_calc, err);
`else
    modport master (output in_data, in_valid, op, input ans, done_calc);
    modport slave  (input in_data, in_valid, op, output ans, done_calc);
`endif

endinterface : calc_16_if

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative DATA_W x DATA_W unsigned multiplier, one multiplier
// bit per cycle, always DATA_W cycles (no early exit).
//   clk, rst_n   clock, async active-low reset
//   start_i      load a_i/b_i and begin (one-cycle pulse)
//   a_i, b_i     multiplicand / multiplier
//   busy_o       iteration in progress (registered)
//   done_c       final iteration this cycle (combinational)
//   product_c    full product, valid while done_c is high (combinational)
module shift_add_mul
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W = CALC_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic                busy_o,
    output logic                done_c,
    output logic [2*DATA_W-1:0] product_c
);

    localparam int unsigned P_W   = 2 * DATA_W;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic             busy_q,  busy_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [P_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0] mlier_q, mlier_d;
    logic [P_W-1:0]   acc_q,   acc_d;
    logic [P_W-1:0]   sum_c;

    // Accumulate this cycle's partial product; on the last iteration it is the result.
    assign sum_c     = acc_q + (mlier_q[0] ? mcand_q : '0);
    assign done_c    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign product_c = sum_c;
    assign busy_o    = busy_q;

    // Next-state datapath
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mlier_d = mlier_q;
        acc_d   = acc_q;
        if (start_i) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            mcand_d = P_W'(a_i);
            mlier_d = b_i;
            acc_d   = '0;
        end else if (busy_q) begin
            acc_d   = sum_c;
            mcand_d = mcand_q << 1;
            mlier_d = mlier_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (done_c) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            mlier_q <= '0;
            acc_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mlier_q <= mlier_d;
            acc_q   <= acc_d;
        end
    end

endmodule : shift_add_mul

// File: rtl/calc_16.sv
// calc_16: collects operands A and B from a byte bus, applies add/sub/mul/concat
// and presents the 2*DATA_W-bit result on ans with done_calc high for
// DONE_CYCLES cycles. Multiply takes DATA_W cycles; other ops take one.
//   clock, reset_n  clock, async active-low reset (aborts any operation)
//   bus (slave)     in_data/in_valid/op in; ans/done_calc (and err) out
// Optional macro CALC_ERR_EN: adds bus.err, a one-cycle pulse after each edge
// where an in_valid byte was dropped in MUL or DONE.
module calc_16
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W      = CALC_DATA_W,
    parameter int unsigned DONE_CYCLES = CALC_DONE_CYCLES
) (
    input  logic       clock,
    input  logic       reset_n,
    calc_16_if.slave   bus
);

    localparam int unsigned P_W  = 2 * DATA_W;
    localparam int unsigned DC_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q,     a_d;
    logic [P_W-1:0]    ans_q,   ans_d;
    logic              done_q,  done_d;
    logic [DC_W-1:0]   dcnt_q,  dcnt_d;

    logic              mul_start_c;
    logic              mul_busy;
    logic              mul_done_c;
    logic [P_W-1:0]    mul_product_c;
    logic [DATA_W:0]   add_c;
    op_t               op_c;

    assign op_c  = op_t'(bus.op);
    assign add_c = {1'b0, a_q} + {1'b0, bus.in_data};

    shift_add_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (clock),
        .rst_n     (reset_n),
        .start_i   (mul_start_c),
        .a_i       (a_q),
        .b_i       (bus.in_data),
        .busy_o    (mul_busy),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        ans_d       = ans_q;
        done_d      = done_q;
        dcnt_d      = dcnt_q;
        mul_start_c = 1'b0;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (bus.in_valid) begin
                    a_d     = bus.in_data;
                    state_d = GOT_A;
                end
            end
            GOT_A: begin
                if (bus.in_valid) begin
                    // Single-cycle ops open the result window directly.
                    state_d = DONE;
                    done_d  = 1'b1;
                    dcnt_d  = '0;
                    case (op_c)
                        OP_ADD:  ans_d = P_W'(add_c);
                        OP_SUB:  ans_d = P_W'(a_q) - P_W'(bus.in_data);
                        OP_CAT:  ans_d = {a_q, bus.in_data};
                        default: begin
                            state_d     = MUL;
                            done_d      = 1'b0;
                            mul_start_c = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                if (mul_done_c) begin
                    ans_d   = mul_product_c;
                    done_d  = 1'b1;
                    dcnt_d  = '0;
                    state_d = DONE;
                end else if (!mul_busy) begin
                    // Multiplier idle without finishing: recover to IDLE.
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (dcnt_q == DC_W'(DONE_CYCLES - 1)) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + DC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            ans_q   <= '0;
            done_q  <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            ans_q   <= ans_d;
            done_q  <= done_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign bus.ans       = ans_q;
    assign bus.done_calc = done_q;

`ifdef CALC_ERR_EN
    logic err_q;

    // Flag a byte that arrived while busy computing or presenting a result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bus.in_valid && ((state_q == MUL) || (state_q == DONE));
        end
    end

    assign bus.err = err_q;
`endif

endmodule : calc_16
